alu_cmd_issuer: RTL

Synthesizable initiator for the ALU operand interface. It accepts operation requests on a valid/ready port and drives the ALU input pins: OPA, OPB, INP_VALID, CE, MODE, CIN and CMD. Operands are issued either together or split across cycles with a programmable gap. After the command-dependent latency it captures RES and the flags and returns them on a valid/ready response port. It sits between a command source (CPU-side register block or traffic generator) and ALU_DESIGN.

---
 rtl/alu_cmd_pkg.sv | 32 +++
 rtl/alu_issue_timer.sv | 26 ++
 rtl/alu_cmd_issuer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_pkg.sv
// Shared types and constants for the ALU command issuer.
package alu_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_A,
    GAP,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Bit positions inside rsp_flags = {ERR, OFLOW, COUT, G, E, L}
  localparam int unsigned FLG_ERR   = 5;
  localparam int unsigned FLG_OFLOW = 4;
  localparam int unsigned FLG_COUT  = 3;
  localparam int unsigned FLG_G     = 2;
  localparam int unsigned FLG_E     = 1;
  localparam int unsigned FLG_L     = 0;

  localparam int unsigned CMD_MAX_W = 8;
  localparam logic [CMD_MAX_W-1:0] CMD_MUL_INC = 8'd9;
  localparam logic [CMD_MAX_W-1:0] CMD_MUL_SHL = 8'd10;

  // Result latency in cycles after the full-operand issue cycle.
  function automatic logic [1:0] lat_of(input logic mode, input logic [CMD_MAX_W-1:0] cmd);
    if (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL))
      return 2'd2;
    return 2'd1;
  endfunction

endpackage

// File: rtl/alu_issue_timer.sv
// Loadable down-counter; done flags the final counted cycle while enabled.
module alu_issue_timer #(
  parameter int unsigned W = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = en && (cnt == W'(1));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one ALU operation at a time (optionally split with a gap) and
// returns the captured result and flags on a valid/ready response port.
module alu_cmd_issuer
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 4,
  parameter int unsigned GAP_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DW-1:0]     req_opa,
  input  logic [DW-1:0]     req_opb,
  input  logic [CW-1:0]     req_cmd,
  input  logic              req_mode,
  input  logic              req_cin,
  input  logic              req_split,
  input  logic [GAP_W-1:0]  req_gap,
  output logic [DW-1:0]     OPA,
  output logic [DW-1:0]     OPB,
  output logic [1:0]        INP_VALID,
  output logic              CE,
  output logic              MODE,
  output logic              CIN,
  output logic [CW-1:0]     CMD,
  input  logic [2*DW-1:0]   RES,
  input  logic              COUT,
  input  logic              OFLOW,
  input  logic              G,
  input  logic              E,
  input  logic              L,
  input  logic              ERR,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*DW-1:0]   rsp_res,
  output logic [5:0]        rsp_flags
);

  state_t             state_q, state_d;
  logic               armed_q;
  logic [DW-1:0]      opa_q, opb_q;
  logic [CW-1:0]      cmd_q;
  logic               mode_q, cin_q;
  logic [GAP_W-1:0]   gap_q;
  logic [2*DW-1:0]    res_q;
  logic [5:0]         flags_q, flags_in;
  logic               accept, capture;
  logic               tmr_load, tmr_en, tmr_done;
  logic [GAP_W-1:0]   tmr_val;

  // armed_q keeps req_ready low while in reset and until the first edge after release
  assign req_ready = armed_q && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;

  always_comb begin
    flags_in            = '0;
    flags_in[FLG_ERR]   = ERR;
    flags_in[FLG_OFLOW] = OFLOW;
    flags_in[FLG_COUT]  = COUT;
    flags_in[FLG_G]     = G;
    flags_in[FLG_E]     = E;
    flags_in[FLG_L]     = L;
  end

  alu_issue_timer #(.W(GAP_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      gap_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (accept) begin
        opa_q  <= req_opa;
        opb_q  <= req_opb;
        cmd_q  <= req_cmd;
        mode_q <= req_mode;
        cin_q  <= req_cin;
        gap_q  <= req_gap;
      end
      if (capture) begin
        res_q   <= RES;
        flags_q <= flags_in;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    capture   = 1'b0;
    OPA       = '0;
    OPB       = '0;
    CMD       = '0;
    MODE      = 1'b0;
    CIN       = 1'b0;
    CE        = 1'b0;
    INP_VALID = 2'b00;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = req_split ? ISSUE_A : ISSUE;
      end
      ISSUE_A, GAP: begin
        OPA  = opa_q;
        CMD  = cmd_q;
        MODE = mode_q;
        CIN  = cin_q;
        CE   = 1'b1;
        if (state_q == ISSUE_A) begin
          INP_VALID = 2'b01;
          if (gap_q != '0) begin
            tmr_load = 1'b1;
            tmr_val  = gap_q;
            state_d  = GAP;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_done)
            state_d = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        OPA  = opa_q;
        OPB  = opb_q;
        CMD  = cmd_q;
        MODE = mode_q;
        CIN  = cin_q;
        CE   = 1'b1;
        if (state_q == ISSUE) begin
          INP_VALID = 2'b11;
          tmr_load  = 1'b1;
          tmr_val   = GAP_W'(lat_of(mode_q, CMD_MAX_W'(cmd_q)));
          state_d   = WAIT;
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            capture = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
